// File: rtl/mat_switch_pkg.sv
// rtl/mat_switch_pkg.sv - shared word/vector types and index width helper for the MatCore switch
package mat_switch_pkg;

  localparam int WORD_BITS = 32;
  localparam int VEC_WORDS = 16;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef word_t [VEC_WORDS-1:0] vec_t;

  // Keep at least one index bit so a single-core switch still has legal port widths.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_switch_slot.sv
// rtl/mat_switch_slot.sv - single-entry mailbox for one (source, destination) pair
module mat_switch_slot
  import mat_switch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [WIDTH-1:0][WORD_BITS-1:0]  wr_data,
  input  logic                             rd_en,
  output logic                             valid,
  output logic [WIDTH-1:0][WORD_BITS-1:0]  rd_data
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while valid is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/mat_switch.sv
// rtl/mat_switch.sv - NxN mailbox switch serving send/receive handshakes for MatCore cores
module mat_switch
  import mat_switch_pkg::*;
#(
  parameter int  SWITCH_CORE_SIZE      = 4,
  parameter int  SWITCH_WIDTH          = 16,
  localparam int SWITCH_CORE_ADDR_SIZE = idx_width(SWITCH_CORE_SIZE)
) (
  input  logic                                                       clock,
  input  logic                                                       reset_n,
  input  logic [SWITCH_CORE_SIZE-1:0]                                switch_send_ready,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]     switch_send_core_idx,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                                switch_send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                                switch_recv_request,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]     switch_recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                                switch_recv_ready,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_recv_data
);

  localparam int N = SWITCH_CORE_SIZE;
  localparam int A = SWITCH_CORE_ADDR_SIZE;

  logic [N-1:0][N-1:0]                                slot_valid;
  logic [N-1:0][N-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] slot_rdata;
  logic [N-1:0][N-1:0]                                slot_wr;
  logic [N-1:0][N-1:0]                                slot_rd;
  logic [N-1:0]                                       send_accept;
  logic [N-1:0]                                       recv_serve;
  logic [N-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0]      serve_data;

  for (genvar s = 0; s < N; s++) begin : g_src
    for (genvar d = 0; d < N; d++) begin : g_dst
      mat_switch_slot #(.WIDTH(SWITCH_WIDTH)) u_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (slot_wr[s][d]),
        .wr_data (switch_send_data[s]),
        .rd_en   (slot_rd[s][d]),
        .valid   (slot_valid[s][d]),
        .rd_data (slot_rdata[s][d])
      );
    end
  end

  // Decode walks every legal index, so an out-of-range idx simply matches nothing.
  always_comb begin
    slot_wr     = '0;
    slot_rd     = '0;
    send_accept = '0;
    recv_serve  = '0;
    serve_data  = '0;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (switch_send_ready[s] && !switch_send_ok[s] &&
            switch_send_core_idx[s] == A'(d) && !slot_valid[s][d]) begin
          slot_wr[s][d]  = 1'b1;
          send_accept[s] = 1'b1;
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int s = 0; s < N; s++) begin
        if (switch_recv_request[r] && !switch_recv_ready[r] &&
            switch_recv_core_idx[r] == A'(s) && slot_valid[s][r]) begin
          slot_rd[s][r] = 1'b1;
          recv_serve[r] = 1'b1;
          serve_data[r] = slot_rdata[s][r];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      switch_send_ok    <= '0;
      switch_recv_ready <= '0;
      switch_recv_data  <= '0;
    end else begin
      switch_send_ok    <= send_accept;
      switch_recv_ready <= recv_serve;
      for (int r = 0; r < N; r++) begin
        if (recv_serve[r]) begin
          switch_recv_data[r] <= serve_data[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_switch.sv
// tb/tb_mat_switch.sv - directed self-checking bench for mat_switch with a mailbox reference model
module tb_mat_switch;

  localparam int N = 4;
  localparam int W = 16;

  logic                       clock = 1'b0;
  logic                       reset_n = 1'b0;
  logic [N-1:0]               send_ready = '0;
  logic [N-1:0][1:0]          send_idx = '0;
  logic [N-1:0][W-1:0][31:0]  send_data = '0;
  logic [N-1:0]               send_ok;
  logic [N-1:0]               recv_request = '0;
  logic [N-1:0][1:0]          recv_idx = '0;
  logic [N-1:0]               recv_ready;
  logic [N-1:0][W-1:0][31:0]  recv_data;

  int n_vec = 0;
  int n_err = 0;

  mat_switch #(.SWITCH_CORE_SIZE(N), .SWITCH_WIDTH(W)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .switch_send_ready    (send_ready),
    .switch_send_core_idx (send_idx),
    .switch_send_data     (send_data),
    .switch_send_ok       (send_ok),
    .switch_recv_request  (recv_request),
    .switch_recv_core_idx (recv_idx),
    .switch_recv_ready    (recv_ready),
    .switch_recv_data     (recv_data)
  );

  always #5 clock = ~clock;

  // Mailbox model: full flag and payload per (source, destination) pair.
  logic [N-1:0][N-1:0]        mb_full = '0;
  logic [511:0]               mb_data [N][N];
  logic [N-1:0]               exp_ok = '0;
  logic [N-1:0]               exp_rr = '0;
  logic [511:0]               exp_data [N];
  logic [N-1:0]               m_acc;
  logic [N-1:0]               m_srv;

  initial for (int r = 0; r < N; r++) exp_data[r] = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mb_full = '0;
      exp_ok  = '0;
      exp_rr  = '0;
      for (int r = 0; r < N; r++) exp_data[r] = '0;
    end else begin
      for (int s = 0; s < N; s++)
        m_acc[s] = send_ready[s] && !exp_ok[s] && !mb_full[s][send_idx[s]];
      for (int r = 0; r < N; r++)
        m_srv[r] = recv_request[r] && !exp_rr[r] && mb_full[recv_idx[r]][r];
      for (int r = 0; r < N; r++) begin
        if (m_srv[r]) begin
          exp_data[r] = mb_data[recv_idx[r]][r];
          mb_full[recv_idx[r]][r] = 1'b0;
        end
      end
      for (int s = 0; s < N; s++) begin
        if (m_acc[s]) begin
          mb_data[s][send_idx[s]] = send_data[s];
          mb_full[s][send_idx[s]] = 1'b1;
        end
      end
      exp_ok = m_acc;
      exp_rr = m_srv;
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    check("send_ok", 512'(send_ok), 512'(exp_ok));
    check("recv_ready", 512'(recv_ready), 512'(exp_rr));
    for (int r = 0; r < N; r++)
      check($sformatf("recv_data[%0d]", r), recv_data[r], exp_data[r]);
  end

  function automatic logic [511:0] mkvec(input logic [31:0] base);
    logic [511:0] v;
    for (int i = 0; i < W; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_send(input int c, input int dst, input logic [511:0] v);
    send_ready[c] = 1'b1;
    send_idx[c]   = 2'(dst);
    send_data[c]  = v;
  endtask

  task automatic set_recv(input int c, input int src);
    recv_request[c] = 1'b1;
    recv_idx[c]     = 2'(src);
  endtask

  int pulses;

  initial begin
    repeat (2) tick();
    check("reset send_ok", 512'(send_ok), 512'd0);
    check("reset recv_ready", 512'(recv_ready), 512'd0);
    reset_n = 1'b1;
    tick();

    // Basic transfer 0 -> 2
    set_send(0, 2, mkvec(32'd1));
    tick();
    check("t1 send_ok", 512'(send_ok), 512'b0001);
    send_ready[0] = 1'b0;
    tick();
    check("t1 send_ok drop", 512'(send_ok), 512'd0);
    set_recv(2, 0);
    tick();
    check("t1 recv_ready", 512'(recv_ready), 512'b0100);
    check("t1 word0", 512'(recv_data[2][0]), 512'd1);
    check("t1 word15", 512'(recv_data[2][15]), 512'd16);
    tick();
    check("t1 recv_ready drop", 512'(recv_ready), 512'd0);
    check("t1 data held", 512'(recv_data[2][7]), 512'd8);
    repeat (2) tick();
    check("t1 slot empty", 512'(recv_ready), 512'd0);
    recv_request[2] = 1'b0;

    // Blocking on full slot 1 -> 3
    set_send(1, 3, mkvec(32'hA000));
    tick();
    check("t2 first ok", 512'(send_ok), 512'b0010);
    set_send(1, 3, mkvec(32'hB000));
    tick();
    tick();
    check("t2 blocked", 512'(send_ok), 512'd0);
    set_recv(3, 1);
    tick();
    check("t2 recv A", 512'(recv_data[3][0]), 512'h0000A000);
    check("t2 still blocked", 512'(send_ok), 512'd0);
    recv_request[3] = 1'b0;
    tick();
    check("t2 B accepted", 512'(send_ok), 512'b0010);
    send_ready[1] = 1'b0;
    tick();
    set_recv(3, 1);
    tick();
    check("t2 recv B", 512'(recv_data[3][1]), 512'h0000B001);
    recv_request[3] = 1'b0;
    tick();

    // Simultaneous on an empty slot, then on a full slot
    set_recv(3, 1);
    set_send(1, 3, mkvec(32'hC000));
    tick();
    check("t3 empty ok", 512'(send_ok), 512'b0010);
    check("t3 empty no serve", 512'(recv_ready), 512'd0);
    send_ready[1] = 1'b0;
    tick();
    check("t3 serve next", 512'(recv_ready), 512'b1000);
    check("t3 data C", 512'(recv_data[3][2]), 512'h0000C002);
    recv_request[3] = 1'b0;
    set_send(1, 3, mkvec(32'hD000));
    tick();
    send_ready[1] = 1'b0;
    tick();
    set_send(1, 3, mkvec(32'hE000));
    set_recv(3, 1);
    tick();
    check("t3 full serve D", 512'(recv_data[3][0]), 512'h0000D000);
    check("t3 full send blocked", 512'(send_ok), 512'd0);
    recv_request[3] = 1'b0;
    tick();
    check("t3 E accepted", 512'(send_ok), 512'b0010);
    send_ready[1] = 1'b0;
    set_recv(3, 1);
    tick();
    check("t3 recv E", 512'(recv_data[3][0]), 512'h0000E000);
    recv_request[3] = 1'b0;
    tick();

    // Held ready: exactly one acceptance
    pulses = 0;
    set_send(0, 1, mkvec(32'hF000));
    repeat (3) begin
      tick();
      pulses += int'(send_ok[0]);
    end
    check("t4 held pulses", 512'(pulses), 512'd1);
    send_ready[0] = 1'b0;
    set_recv(1, 0);
    tick();
    check("t4 recv F", 512'(recv_data[1][3]), 512'h0000F003);
    recv_request[1] = 1'b0;
    tick();

    // All four cores send to (c+1)%4 together, then receive together
    for (int c = 0; c < N; c++) set_send(c, (c + 1) % N, mkvec(32'h100 * (c + 1)));
    tick();
    check("t4 all ok", 512'(send_ok), 512'hF);
    send_ready = '0;
    tick();
    for (int r = 0; r < N; r++) set_recv(r, (r + N - 1) % N);
    tick();
    check("t4 all ready", 512'(recv_ready), 512'hF);
    check("t4 core0 from 3", 512'(recv_data[0][0]), 512'h400);
    check("t4 core2 from 1", 512'(recv_data[2][5]), 512'h205);
    recv_request = '0;
    tick();

    // Reset mid-operation discards buffered vectors
    set_send(0, 1, mkvec(32'h1234));
    set_send(2, 2, mkvec(32'h5678));
    tick();
    send_ready = '0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t5 async ok", 512'(send_ok), 512'd0);
    check("t5 async rr", 512'(recv_ready), 512'd0);
    check("t5 async data", recv_data[3], 512'd0);
    tick();
    reset_n = 1'b1;
    set_recv(1, 0);
    set_recv(2, 2);
    pulses = 0;
    repeat (3) begin
      tick();
      pulses += int'(recv_ready[1]) + int'(recv_ready[2]);
    end
    check("t5 never served", 512'(pulses), 512'd0);
    recv_request = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
